// File: rtl/clint_regfile_if.sv
// RAM-like access port between the AXI-Lite slave adapter (master) and the CLINT register core (slave).
interface clint_regfile_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
);

  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic                      en;
  logic                      we;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_DATA_WIDTH-1:0] rdata;

  modport master (
    output addr,
    output en,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  en,
    input  we,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/clint_regfile.sv
// RISC-V CLINT register core: mtime counter, per-hart mtimecmp and msip, timer/software interrupt outputs.
// Optional macro CLINT_RTC_SYNC_EN: pass rtc_i through a 2-flop synchronizer before edge detection.
module clint_regfile #(
  parameter int unsigned NR_HARTS       = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  clint_regfile_if.slave      bus,
  input  logic                rtc_i,
  output logic [NR_HARTS-1:0] timer_irq_o,
  output logic [NR_HARTS-1:0] ipi_o
);

  localparam logic [12:0] MTIME_WORD    = 13'h17FF;
  localparam logic [12:0] CMP_BASE_WORD = 13'h0800;
  localparam logic [12:0] HARTS         = 13'(NR_HARTS);

  logic [15:0]               off;
  logic [12:0]               word;
  logic [12:0]               msipHart;
  logic [12:0]               cmpHart;
  logic                      selMsip;
  logic                      selCmp;
  logic                      selMtime;
  logic                      wrEn;
  logic                      rdEn;
  logic [63:0]               wdata;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic                      unusedAddrBits;

  logic [63:0]         mtime_q;
  logic [63:0]         mtime_d;
  logic [63:0]         mtimecmp_q [NR_HARTS];
  logic [63:0]         mtimecmp_d [NR_HARTS];
  logic [NR_HARTS-1:0] msip_q;
  logic [NR_HARTS-1:0] msip_d;
  logic [NR_HARTS-1:0] timerIrq_q;
  logic [NR_HARTS-1:0] timerIrq_d;
  logic                rtcPrev_q;
  logic                rtcSample;
  logic                tick;

  assign off            = bus.addr[15:0];
  assign word           = off[15:3];
  assign wdata          = bus.wdata;
  assign wrEn           = bus.en & bus.we;
  assign rdEn           = bus.en & ~bus.we;
  assign unusedAddrBits = ^{bus.addr[AXI_ADDR_WIDTH-1:16], bus.addr[2:0]};

  // Decode is per 64-bit word; anything below 0x4000 is MSIP, each word covering two harts.
  always_comb begin
    msipHart = {1'b0, word[10:0], 1'b0};
    cmpHart  = word - CMP_BASE_WORD;
    selMtime = (word == MTIME_WORD);
    selMsip  = (word[12:11] == 2'b00) && (msipHart < HARTS);
    selCmp   = (word >= CMP_BASE_WORD) && !selMtime && (cmpHart < HARTS);
  end

  always_comb begin
    rdata = '0;
    if (rdEn) begin
      if (selMtime) begin
        rdata = mtime_q;
      end
      for (int h = 0; h < int'(NR_HARTS); h++) begin
        if (selCmp && (cmpHart == 13'(h))) begin
          rdata = mtimecmp_q[h];
        end
        if (selMsip && (msipHart == 13'(h))) begin
          rdata[0] = msip_q[h];
        end
        if (selMsip && ((msipHart | 13'd1) == 13'(h))) begin
          rdata[32] = msip_q[h];
        end
      end
    end
  end

  assign bus.rdata = rdata;

`ifdef CLINT_RTC_SYNC_EN
  logic [1:0] rtcSync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rtcSync_q <= '0;
    end else begin
      rtcSync_q <= {rtcSync_q[0], rtc_i};
    end
  end

  assign rtcSample = rtcSync_q[1];
`else
  assign rtcSample = rtc_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rtcPrev_q <= 1'b0;
    end else begin
      rtcPrev_q <= rtcSample;
    end
  end

  assign tick = rtcSample & ~rtcPrev_q;

  // A software write to mtime overrides a coincident tick; mtimecmp writes and ticks combine.
  always_comb begin
    mtime_d    = mtime_q + 64'(tick);
    msip_d     = msip_q;
    timerIrq_d = '0;
    if (wrEn && selMtime) begin
      mtime_d = wdata;
    end
    for (int h = 0; h < int'(NR_HARTS); h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wrEn && selCmp && (cmpHart == 13'(h))) begin
        mtimecmp_d[h] = wdata;
      end
      if (wrEn && selMsip && (msipHart == 13'(h))) begin
        msip_d[h] = wdata[0];
      end
      if (wrEn && selMsip && ((msipHart | 13'd1) == 13'(h))) begin
        msip_d[h] = wdata[32];
      end
      timerIrq_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      msip_q     <= '0;
      timerIrq_q <= '0;
      for (int h = 0; h < int'(NR_HARTS); h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      mtime_q    <= mtime_d;
      msip_q     <= msip_d;
      timerIrq_q <= timerIrq_d;
      for (int h = 0; h < int'(NR_HARTS); h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  assign timer_irq_o = timerIrq_q;
  assign ipi_o       = msip_q;

endmodule

// File: tb/tb_clint_regfile.sv
// Bench for clint_regfile with two harts: directed scenarios plus random traffic, checked every cycle
// against a behavioural CLINT model.
module tb_clint_regfile;

  localparam int NR = 2;
`ifdef CLINT_RTC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int PH = 3;
  localparam logic [63:0] MTIME_A = 64'hBFF8;
  localparam logic [63:0] CMP0_A  = 64'h4000;
  localparam logic [63:0] CMP1_A  = 64'h4008;
  localparam logic [63:0] MSIP_A  = 64'h0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rtc = 1'b0;
  logic [NR-1:0] timerIrq;
  logic [NR-1:0] ipi;
  int            errors = 0;
  int            checks = 0;
  bit            checkEn = 1'b0;

  clint_regfile_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) bus ();

  clint_regfile #(
    .NR_HARTS(NR),
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .rtc_i(rtc),
    .timer_irq_o(timerIrq),
    .ipi_o(ipi)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural registers plus the rtc level seen at each clock edge.
  logic [63:0] mtimeM;
  logic [63:0] cmpM [NR];
  logic [NR-1:0] msipM;
  logic [NR-1:0] irqM;
  logic [3:0]  rtcHist;

  function automatic int wordOff(input logic [63:0] addr);
    return int'(addr[15:3]) * 8;
  endfunction

  function automatic logic [63:0] modelRead(input logic [63:0] addr);
    int off = wordOff(addr);
    logic [63:0] v = '0;
    if (off == 'hBFF8) v = mtimeM;
    else if (off >= 'h4000 && off < 'h4000 + 8 * NR) v = cmpM[(off - 'h4000) / 8];
    else if (off < 'h4000) begin
      if (2 * (off / 8) < NR) v[0] = msipM[2 * (off / 8)];
      if (2 * (off / 8) + 1 < NR) v[32] = msipM[2 * (off / 8) + 1];
    end
    return v;
  endfunction

  task automatic modelStep();
    int off;
    bit tick;
    bit mtimeWr = 1'b0;
    for (int h = 0; h < NR; h++) irqM[h] = (mtimeM >= cmpM[h]);
    rtcHist = {rtcHist[2:0], rtc};
    tick = rtcHist[LAT-1] & ~rtcHist[LAT];
    if (bus.en && bus.we) begin
      off = wordOff(bus.addr);
      if (off == 'hBFF8) begin
        mtimeM  = bus.wdata;
        mtimeWr = 1'b1;
      end else if (off >= 'h4000 && off < 'h4000 + 8 * NR) begin
        cmpM[(off - 'h4000) / 8] = bus.wdata;
      end else if (off < 'h4000) begin
        if (2 * (off / 8) < NR) msipM[2 * (off / 8)] = bus.wdata[0];
        if (2 * (off / 8) + 1 < NR) msipM[2 * (off / 8) + 1] = bus.wdata[32];
      end
    end
    if (tick && !mtimeWr) mtimeM = mtimeM + 64'd1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mtimeM  = '0;
        msipM   = '0;
        irqM    = '0;
        rtcHist = '0;
        for (int h = 0; h < NR; h++) cmpM[h] = ONES;
      end else begin
        modelStep();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn && !rst) begin
        checkOutput("rdata", bus.rdata, (bus.en && !bus.we) ? modelRead(bus.addr) : 64'd0);
        checkOutput("timer_irq", 64'(timerIrq), 64'(irqM));
        checkOutput("ipi", 64'(ipi), 64'(msipM));
      end
    end
  end

  task automatic applyStimulus(input bit en, input bit we, input logic [63:0] addr,
                               input logic [63:0] wdata, input bit rtcVal);
    @(posedge clk);
    #1;
    bus.en    = en;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    rtc       = rtcVal;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic readCheck(input string name, input logic [63:0] addr, input logic [63:0] expected);
    applyStimulus(1'b1, 1'b0, addr, 64'd0, rtc);
    @(negedge clk);
    checkOutput(name, bus.rdata, expected);
  endtask

  task automatic rtcPeriods(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (PH) applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b1);
      repeat (PH) applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b0);
    end
  endtask

  task automatic randomPhase(input int cycles);
    bit          rtcLvl = rtc;
    int          run = PH;
    logic [15:0] off;
    logic [63:0] addr;
    logic [63:0] wdata;
    for (int i = 0; i < cycles; i++) begin
      case ($urandom_range(0, 7))
        0:       off = 16'h0000;
        1:       off = 16'h0008;
        2:       off = 16'h4000;
        3:       off = 16'h4008;
        4:       off = 16'h4010;
        5:       off = 16'hBFF8;
        6:       off = 16'h8000;
        default: off = 16'($urandom);
      endcase
      addr  = {32'($urandom), 16'($urandom), off[15:3], 3'($urandom)};
      wdata = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 40));
      if (run >= PH && $urandom_range(0, 2) == 0) begin
        rtcLvl = ~rtcLvl;
        run    = 0;
      end
      run++;
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), addr, wdata, rtcLvl);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.en    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    checkEn = 1'b1;

    // Reset values
    readCheck("rst_mtime", MTIME_A, 64'd0);
    readCheck("rst_cmp0", CMP0_A, ONES);
    readCheck("rst_msip", MSIP_A, 64'd0);
    checkOutput("rst_irq", 64'(timerIrq), 64'd0);
    checkOutput("rst_ipi", 64'(ipi), 64'd0);

    // Five rtc periods, then per-edge latency
    rtcPeriods(5);
    readCheck("mtime_5", MTIME_A, 64'd5);
    checkOutput("model_mtime_5", mtimeM, 64'd5);
    applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("lat_before", bus.rdata, 64'd5);
    for (int i = 1; i <= LAT; i++) begin
      nextCycle();
      checkOutput("lat_edge", bus.rdata, (i >= LAT) ? 64'd6 : 64'd5);
    end
    applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b1);
    repeat (PH) applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b0);

    // Timer interrupt rise and clear
    applyStimulus(1'b1, 1'b1, MTIME_A, 64'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, CMP0_A, 64'd3, 1'b0);
    rtcPeriods(3);
    readCheck("mtime_3", MTIME_A, 64'd3);
    checkOutput("irq0_set", 64'(timerIrq[0]), 64'd1);
    checkOutput("irq1_idle", 64'(timerIrq[1]), 64'd0);
    applyStimulus(1'b1, 1'b1, CMP0_A, 64'd10, 1'b0);
    nextCycle();
    checkOutput("irq0_hold", 64'(timerIrq[0]), 64'd1);
    nextCycle();
    checkOutput("irq0_clear", 64'(timerIrq[0]), 64'd0);

    // Software interrupts for both harts in one MSIP word
    applyStimulus(1'b1, 1'b1, MSIP_A, 64'h0000_0001_0000_0001, 1'b0);
    nextCycle();
    checkOutput("ipi_set", 64'(ipi), 64'd3);
    readCheck("msip_read", MSIP_A, 64'h0000_0001_0000_0001);
    applyStimulus(1'b1, 1'b1, MSIP_A, 64'd0, 1'b0);
    nextCycle();
    checkOutput("ipi_clear", 64'(ipi), 64'd0);

    // mtime wrap, then write beating a coincident tick
    applyStimulus(1'b1, 1'b1, MTIME_A, ONES, 1'b0);
    rtcPeriods(1);
    readCheck("mtime_wrap", MTIME_A, 64'd0);
    for (int i = 0; i < LAT; i++) begin
      applyStimulus(i == LAT - 1, i == LAT - 1, MTIME_A, 64'd7, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("mtime_wr_wins", bus.rdata, 64'd7);
    applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b1);
    repeat (PH) applyStimulus(1'b1, 1'b0, MTIME_A, 64'd0, 1'b0);
    readCheck("mtime_no_extra", MTIME_A, 64'd7);

    // Unmapped and out-of-range harts
    readCheck("rd_8000", 64'h8000, 64'd0);
    readCheck("rd_cmp2", 64'h4010, 64'd0);
    readCheck("rd_msip1", 64'h0008, 64'd0);
    applyStimulus(1'b1, 1'b1, 64'h8000, 64'h55, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h4010, 64'h66, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h0008, ONES, 1'b0);
    readCheck("cmp0_kept", CMP0_A, 64'd10);
    readCheck("cmp1_kept", CMP1_A, ONES);
    readCheck("msip_kept", MSIP_A, 64'd0);
    readCheck("mtime_kept", MTIME_A, 64'd7);
    checkOutput("ipi_kept", 64'(ipi), 64'd0);

    randomPhase(400);

    // Reset in the middle of a write
    applyStimulus(1'b1, 1'b1, MSIP_A, 64'h0000_0001_0000_0001, 1'b0);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    bus.we = 1'b0;
    checkOutput("midrst_irq", 64'(timerIrq), 64'd0);
    checkOutput("midrst_ipi", 64'(ipi), 64'd0);
    rst = 1'b0;
    readCheck("midrst_mtime", MTIME_A, 64'd0);
    readCheck("midrst_cmp0", CMP0_A, ONES);
    readCheck("midrst_cmp1", CMP1_A, ONES);
    readCheck("midrst_msip", MSIP_A, 64'd0);

    randomPhase(200);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
